// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/DM backing-memory arbiter.
// FSM states and grant-owner codes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_SERVE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and MA data port onto one memory.
// DM has fixed priority, bounded by a streak limiter for waiting fetches.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IF_READ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic [DATA_W-1:0] IF_RDATA,
    output logic              IF_BUSYWAIT,
    input  logic              DM_READ,
    input  logic              DM_WRITE,
    input  logic [ADDR_W-1:0] DM_ADDR,
    input  logic [DATA_W-1:0] DM_WDATA,
    output logic [DATA_W-1:0] DM_RDATA,
    output logic              DM_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              GRANT_DM
);

    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic dm_req;
    logic own_dm;
    logic serve;
    logic resp;
    logic mem_wr;

    assign dm_req = DM_READ | DM_WRITE;
    assign own_dm = (owner_q == OWN_DM);
    assign serve  = (state_q == ARB_SERVE);
    assign resp   = (state_q == ARB_RESP);
    assign mem_wr = own_dm & DM_WRITE;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            streak_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        streak_d   = streak_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (!IF_READ) streak_d = '0;
                if (dm_req && (streak_q < STREAK_MAX || !IF_READ)) begin
                    state_d = ARB_SERVE;
                    owner_d = OWN_DM;
                    if (IF_READ) streak_d = streak_q + SW'(1);
                end else if (IF_READ) begin
                    state_d  = ARB_SERVE;
                    owner_d  = OWN_IF;
                    streak_d = '0;
                end
            end
            ARB_SERVE: begin
                // A dropped request still finishes; its data is discarded.
                if (!MEM_BUSYWAIT) begin
                    state_d = ARB_RESP;
                    if (own_dm && DM_READ && !DM_WRITE) dm_rdata_d = MEM_RDATA;
                    if (!own_dm && IF_READ) if_rdata_d = MEM_RDATA;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        MEM_READ    = serve & ~mem_wr;
        MEM_WRITE   = serve & mem_wr;
        MEM_ADDR    = '0;
        MEM_WDATA   = '0;
        if (serve) MEM_ADDR = own_dm ? DM_ADDR : IF_ADDR;
        if (serve && mem_wr) MEM_WDATA = DM_WDATA;
        IF_BUSYWAIT = RESET & IF_READ & ~(resp & ~own_dm);
        DM_BUSYWAIT = RESET & dm_req & ~(resp & own_dm);
        GRANT_DM    = own_dm;
        IF_RDATA    = if_rdata_q;
        DM_RDATA    = dm_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a wait-state memory model.
// Expected memory and response events are queued with their cycle stamps.
module tb_mem_port_arbiter;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_exp_t;

    logic        CLK;
    logic        RESET;
    logic        IF_READ;
    logic [31:0] IF_ADDR;
    logic [31:0] IF_RDATA;
    logic        IF_BUSYWAIT;
    logic        DM_READ;
    logic        DM_WRITE;
    logic [31:0] DM_ADDR;
    logic [31:0] DM_WDATA;
    logic [31:0] DM_RDATA;
    logic        DM_BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;
    logic        MEM_BUSYWAIT;
    logic        GRANT_DM;

    int cyc = 0;
    int wcnt = 0;
    int wait_cfg = 0;
    int checks = 0;
    int errors = 0;
    int wr_cycles = 0;

    logic [31:0] mem [0:255];
    bit          written [0:255];

    mem_exp_t mem_q[$];
    rsp_exp_t if_q[$];
    rsp_exp_t dm_q[$];

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_DM_STREAK(4)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .IF_READ(IF_READ),
        .IF_ADDR(IF_ADDR),
        .IF_RDATA(IF_RDATA),
        .IF_BUSYWAIT(IF_BUSYWAIT),
        .DM_READ(DM_READ),
        .DM_WRITE(DM_WRITE),
        .DM_ADDR(DM_ADDR),
        .DM_WDATA(DM_WDATA),
        .DM_RDATA(DM_RDATA),
        .DM_BUSYWAIT(DM_BUSYWAIT),
        .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE),
        .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .GRANT_DM(GRANT_DM)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        case (a)
            32'h10:  init_val = 32'h0050_0093;
            32'h20:  init_val = 32'h00A0_0113;
            32'h30:  init_val = 32'h00C0_0193;
            32'h100: init_val = 32'h1122_3344;
            32'h200, 32'h204, 32'h208, 32'h20C, 32'h210:
                     init_val = 32'h5000_0000 | a;
            default: init_val = 32'hBAD0_0000 ^ a;
        endcase
    endfunction

    // Memory model: busy for wait_cfg cycles after the strobe rises.
    always @(posedge CLK) begin
        if (!(MEM_READ || MEM_WRITE)) begin
            wcnt <= wait_cfg;
        end else if (wcnt != 0) begin
            wcnt <= wcnt - 1;
        end else if (MEM_WRITE) begin
            mem[MEM_ADDR[9:2]]     <= MEM_WDATA;
            written[MEM_ADDR[9:2]] <= 1'b1;
        end
    end

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (wcnt != 0);

    always @* begin
        if (written[MEM_ADDR[9:2]]) MEM_RDATA = mem[MEM_ADDR[9:2]];
        else MEM_RDATA = init_val(MEM_ADDR);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic do_if(input logic [31:0] a, input int rc,
                         input logic [31:0] rd, input int mc);
        mem_exp_t m;
        rsp_exp_t r;
        bit done;
        m.cyc = mc; m.wr = 1'b0; m.addr = a; m.data = '0;
        r.cyc = rc; r.data = rd;
        mem_q.push_back(m);
        if_q.push_back(r);
        IF_ADDR = a;
        IF_READ = 1'b1;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            if (!IF_BUSYWAIT) done = 1;
        end
        if (!done) chk("if_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1 IF_READ = 1'b0;
    endtask

    task automatic do_dm(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int rc, input logic [31:0] rdat,
                         input int mc);
        mem_exp_t m;
        rsp_exp_t r;
        bit done;
        m.cyc = mc; m.wr = wr; m.addr = a; m.data = wr ? wd : '0;
        r.cyc = rc; r.data = rdat;
        mem_q.push_back(m);
        dm_q.push_back(r);
        DM_ADDR  = a;
        DM_WDATA = wd;
        DM_READ  = rd;
        DM_WRITE = wr;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            if (!DM_BUSYWAIT) done = 1;
        end
        if (!done) chk("dm_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
        DM_READ  = 1'b0;
        DM_WRITE = 1'b0;
    endtask

    task automatic mon_step();
        int idx;
        rsp_exp_t r;
        if (MEM_WRITE) wr_cycles++;
        if (!RESET) return;
        if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) begin
            idx = -1;
            foreach (mem_q[i]) if (idx < 0 && mem_q[i].cyc == cyc) idx = i;
            if (idx < 0) begin
                chk("mem_unexpected_cyc", MEM_ADDR, 32'hFFFF_FFFF);
            end else begin
                chk("mem_write_strobe", {31'd0, MEM_WRITE},
                    {31'd0, mem_q[idx].wr});
                chk("mem_addr", MEM_ADDR, mem_q[idx].addr);
                if (mem_q[idx].wr) chk("mem_wdata", MEM_WDATA, mem_q[idx].data);
                mem_q.delete(idx);
            end
        end
        if (IF_READ && !IF_BUSYWAIT) begin
            if (if_q.size() == 0) begin
                chk("if_unexpected_rsp", IF_RDATA, 32'hFFFF_FFFF);
            end else begin
                r = if_q.pop_front();
                chk("if_rsp_cycle", 32'(cyc), 32'(r.cyc));
                chk("if_rdata", IF_RDATA, r.data);
            end
        end
        if ((DM_READ || DM_WRITE) && !DM_BUSYWAIT) begin
            if (dm_q.size() == 0) begin
                chk("dm_unexpected_rsp", DM_RDATA, 32'hFFFF_FFFF);
            end else begin
                r = dm_q.pop_front();
                chk("dm_rsp_cycle", 32'(cyc), 32'(r.cyc));
                chk("dm_rdata", DM_RDATA, r.data);
            end
        end
    endtask

    initial begin
        int t0;
        RESET = 1'b0;
        IF_READ = 1'b1;
        IF_ADDR = 32'h10;
        DM_READ = 1'b0;
        DM_WRITE = 1'b0;
        DM_ADDR = '0;
        DM_WDATA = '0;

        fork
            forever begin
                @(negedge CLK);
                mon_step();
            end
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset with a fetch pending: everything quiet.
        repeat (2) @(negedge CLK);
        chk("rst_if_busy", {31'd0, IF_BUSYWAIT}, 32'd0);
        chk("rst_dm_busy", {31'd0, DM_BUSYWAIT}, 32'd0);
        chk("rst_strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
        chk("rst_mem_addr", MEM_ADDR, 32'd0);
        chk("rst_mem_wdata", MEM_WDATA, 32'd0);
        chk("rst_if_rdata", IF_RDATA, 32'd0);
        chk("rst_dm_rdata", DM_RDATA, 32'd0);
        chk("rst_grant_dm", {31'd0, GRANT_DM}, 32'd0);
        @(posedge CLK);
        #1 RESET = 1'b1;
        t0 = cyc;
        #1 chk("rel_if_busy", {31'd0, IF_BUSYWAIT}, 32'd1);

        // Single fetch, zero-wait memory.
        do_if(32'h10, t0 + 2, 32'h0050_0093, t0 + 1);
        chk("if_rdata_hold", IF_RDATA, 32'h0050_0093);
        chk("grant_if", {31'd0, GRANT_DM}, 32'd0);

        // Simultaneous requests: DM first, then IF.
        t0 = cyc;
        fork
            do_dm(1'b1, 1'b0, 32'h100, 32'h0, t0 + 2, 32'h1122_3344, t0 + 1);
            do_if(32'h20, t0 + 5, 32'h00A0_0113, t0 + 4);
        join

        // Store with three memory wait cycles.
        wait_cfg = 3;
        wr_cycles = 0;
        t0 = cyc;
        do_dm(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, t0 + 5, 32'h1122_3344,
              t0 + 4);
        chk("write_strobe_len", 32'(wr_cycles), 32'd4);
        chk("grant_dm", {31'd0, GRANT_DM}, 32'd1);
        wait_cfg = 0;
        t0 = cyc;
        do_dm(1'b1, 1'b0, 32'h104, 32'h0, t0 + 2, 32'hDEAD_BEEF, t0 + 1);

        // Read and write together behave as a write.
        t0 = cyc;
        do_dm(1'b1, 1'b1, 32'h108, 32'hCAFE_F00D, t0 + 2, 32'hDEAD_BEEF,
              t0 + 1);
        t0 = cyc;
        do_dm(1'b1, 1'b0, 32'h108, 32'h0, t0 + 2, 32'hCAFE_F00D, t0 + 1);

        // Back-to-back DM with a waiting fetch: four DM grants, then IF.
        t0 = cyc;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    do_dm(1'b1, 1'b0, 32'h200 + 32'(4 * k), 32'h0,
                          t0 + 2 + 3 * k, 32'h5000_0200 + 32'(4 * k),
                          t0 + 1 + 3 * k);
                do_dm(1'b1, 1'b0, 32'h210, 32'h0, t0 + 17, 32'h5000_0210,
                      t0 + 16);
            end
            do_if(32'h30, t0 + 14, 32'h00C0_0193, t0 + 13);
        join

        // Reset in the middle of a stalled access.
        wait_cfg = 5;
        IF_ADDR = 32'h40;
        IF_READ = 1'b1;
        repeat (2) @(negedge CLK);
        chk("serve_read", {31'd0, MEM_READ}, 32'd1);
        chk("serve_addr", MEM_ADDR, 32'h40);
        #2 RESET = 1'b0;
        #1;
        chk("abort_strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
        chk("abort_addr", MEM_ADDR, 32'd0);
        chk("abort_if_busy", {31'd0, IF_BUSYWAIT}, 32'd0);
        chk("abort_if_rdata", IF_RDATA, 32'd0);
        IF_READ = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b1;
        wait_cfg = 0;
        t0 = cyc;
        do_if(32'h10, t0 + 2, 32'h0050_0093, t0 + 1);

        repeat (3) @(posedge CLK);
        chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
        chk("if_q_empty", 32'(if_q.size()), 32'd0);
        chk("dm_q_empty", 32'(dm_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
